// File: rtl/t03_alu_seq.sv
// t03_alu_seq: handshaked execute unit. Base RV32I ALU ops finish in one
// registered cycle; RV32M mul/div/rem run WIDTH shift-add / restoring steps.
module t03_alu_seq #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic [WIDTH-1:0] imm,
    input  logic             alu_src,
    input  logic             auipc,
    input  logic             lui,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef struct packed {
        logic [4:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    state_t             state_q, state_d;
    req_t               req_q;
    logic [SHW-1:0]     cnt_q;
    logic [2*WIDTH-1:0] prod_q, mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   rem_q, quo_q, dvsr_q;

    logic               accept;
    logic [WIDTH-1:0]   a_in, b_in;

    // Magnitude of x when treated as signed (s=1), else x unchanged.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
        return (s && x[WIDTH-1]) ? -x : x;
    endfunction

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid & in_ready & ~flush;
    assign a_in     = auipc ? pc : (lui ? '0 : rs1);
    assign b_in     = alu_src ? imm : rs2;

    // Operand sign treatment: MULH s*s, MULHSU s*u, MUL/MULHU unsigned; DIV/REM signed.
    logic mul_sa_in, mul_sb_in, div_s_in;
    assign mul_sa_in = op[1] ^ op[0];
    assign mul_sb_in = ~op[1] & op[0];
    assign div_s_in  = ~op[0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: flush overrides everything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = op[4] ? BUSY : DONE;
            BUSY: if (cnt_q == SHW'(WIDTH-1)) state_d = DONE;
            DONE: if (out_valid && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // One restoring-division step: shift in next dividend bit, subtract if it fits.
    logic [WIDTH:0]   rem_sh, rem_sub;
    logic             rem_fit;
    always_comb begin
        rem_sh  = {rem_q, quo_q[WIDTH-1]};
        rem_sub = rem_sh - {1'b0, dvsr_q};
        rem_fit = (rem_sh >= {1'b0, dvsr_q});
    end

    // Final result/flags from captured request and finished accumulators.
    logic [WIDTH:0]     sum_c, dif_c;
    logic [2*WIDTH-1:0] mul_fix;
    logic [WIDTH-1:0]   div_q, div_r, res_c;
    logic               carry_c, ovf_c, mneg, dsg;
    logic [SHW-1:0]     shamt;
    always_comb begin
        sum_c   = {1'b0, req_q.a} + {1'b0, req_q.b};
        dif_c   = {1'b0, req_q.a} - {1'b0, req_q.b};
        shamt   = req_q.b[SHW-1:0];
        mneg    = ((req_q.op[1] ^ req_q.op[0]) & req_q.a[WIDTH-1]) ^
                  ((~req_q.op[1] & req_q.op[0]) & req_q.b[WIDTH-1]);
        mul_fix = mneg ? -prod_q : prod_q;
        dsg     = ~req_q.op[0];
        if (req_q.b == '0) begin
            div_q = '1;
            div_r = req_q.a;
        end else begin
            div_q = (dsg && (req_q.a[WIDTH-1] ^ req_q.b[WIDTH-1])) ? -quo_q : quo_q;
            div_r = (dsg && req_q.a[WIDTH-1]) ? -rem_q : rem_q;
        end
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        if (req_q.op[4]) begin
            case (req_q.op[2:0])
                3'b000:         res_c = mul_fix[WIDTH-1:0];
                3'b001, 3'b010,
                3'b011:         res_c = mul_fix[2*WIDTH-1:WIDTH];
                3'b100, 3'b101: res_c = div_q;
                default:        res_c = div_r;
            endcase
        end else begin
            case (req_q.op[3:0])
                4'b0000: begin
                    res_c   = sum_c[WIDTH-1:0];
                    carry_c = sum_c[WIDTH];
                    ovf_c   = (req_q.a[WIDTH-1] == req_q.b[WIDTH-1]) &&
                              (sum_c[WIDTH-1] != req_q.a[WIDTH-1]);
                end
                4'b1000: begin
                    res_c   = dif_c[WIDTH-1:0];
                    carry_c = (req_q.a < req_q.b);
                    ovf_c   = (req_q.a[WIDTH-1] != req_q.b[WIDTH-1]) &&
                              (dif_c[WIDTH-1] != req_q.a[WIDTH-1]);
                end
                4'b0100: res_c = req_q.a ^ req_q.b;
                4'b0110: res_c = req_q.a | req_q.b;
                4'b0111: res_c = req_q.a & req_q.b;
                4'b0001: res_c = req_q.a << shamt;
                4'b0101: res_c = req_q.a >> shamt;
                4'b1101: res_c = $signed(req_q.a) >>> shamt;
                4'b0010: res_c = {{(WIDTH-1){1'b0}}, $signed(req_q.a) < $signed(req_q.b)};
                4'b0011: res_c = {{(WIDTH-1){1'b0}}, req_q.a < req_q.b};
                default: res_c = '0;
            endcase
        end
    end

    // Datapath: capture on accept, iterate mul/div together while BUSY,
    // register result once on entry to DONE, then hold until handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q     <= '0;
            cnt_q     <= '0;
            prod_q    <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                req_q    <= '{op: op, a: a_in, b: b_in};
                cnt_q    <= '0;
                prod_q   <= '0;
                mcand_q  <= {{WIDTH{1'b0}}, mag(a_in, mul_sa_in)};
                mplier_q <= mag(b_in, mul_sb_in);
                rem_q    <= '0;
                quo_q    <= mag(a_in, div_s_in);
                dvsr_q   <= mag(b_in, div_s_in);
            end
            if (state_q == BUSY) begin
                cnt_q    <= cnt_q + SHW'(1);
                if (mplier_q[0]) prod_q <= prod_q + mcand_q;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                rem_q    <= rem_fit ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                quo_q    <= {quo_q[WIDTH-2:0], rem_fit};
            end
            if (state_q == DONE && !out_valid) begin
                out_valid <= 1'b1;
                result    <= res_c;
                zero      <= (res_c == '0);
                negative  <= res_c[WIDTH-1];
                carry     <= carry_c;
                overflow  <= ovf_c;
            end else if (state_q == DONE && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_t03_alu_seq.sv
// Directed bench for t03_alu_seq: base ops, M ops, latency, hold, flush, reset.
module tb_t03_alu_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, in_ready, alu_src, auipc, lui;
    logic         out_valid, out_ready, zero, negative, carry, overflow;
    logic [4:0]   op;
    logic [W-1:0] pc, rs1, rs2, imm, result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    t03_alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .pc(pc), .rs1(rs1), .rs2(rs2), .imm(imm), .alu_src(alu_src),
        .auipc(auipc), .lui(lui), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .negative(negative), .carry(carry), .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request for a single cycle (accepted at the following posedge).
    task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic src, input logic aui,
                         input logic lu, input logic [31:0] pcv);
        @(negedge clk);
        op = o; rs1 = a; rs2 = b; imm = im; alu_src = src; auipc = aui; lui = lu; pc = pcv;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; alu_src = 1'b0; auipc = 1'b0; lui = 1'b0;
    endtask

    // Full transaction: issue, measure latency, check result/flags {z,n,c,v}, handshake.
    task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] im, input logic src,
                          input logic aui, input logic lu, input logic [31:0] pcv,
                          input int lat, input logic [31:0] exp_res, input logic [3:0] exp_fl);
        int k;
        @(negedge clk);
        chk({tag, "/in_ready"}, 32'(in_ready), 32'd1);
        issue(o, a, b, im, src, aui, lu, pcv);
        k = 0;
        while (!out_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "/lat"}, 32'(k), 32'(lat));
        chk({tag, "/res"}, result, exp_res);
        chk({tag, "/flags"}, 32'({zero, negative, carry, overflow}), 32'(exp_fl));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "/ack"}, 32'({out_valid, in_ready}), 32'b01);
    endtask

    initial begin
        int seen;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; pc = '0; rs1 = '0; rs2 = '0; imm = '0; alu_src = 1'b0; auipc = 1'b0; lui = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset/out_valid", 32'(out_valid), 32'd0);
        chk("reset/in_ready", 32'(in_ready), 32'd1);
        chk("reset/result", result, 32'd0);
        chk("reset/flags", 32'({zero, negative, carry, overflow}), 32'd0);

        // Base ops: expected latency 1 cycle after accept.
        run_op("add_ovf",  5'b00000, 32'h7FFFFFFF, 32'h1, 0, 0, 0, 0, 0, 1, 32'h80000000, 4'b0101);
        run_op("add_cy",   5'b00000, 32'hFFFFFFFF, 32'h1, 0, 0, 0, 0, 0, 1, 32'h0, 4'b1010);
        run_op("sub_eq",   5'b01000, 32'd5, 32'd5, 0, 0, 0, 0, 0, 1, 32'h0, 4'b1000);
        run_op("sub_brw",  5'b01000, 32'd3, 32'd5, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFE, 4'b0110);
        run_op("sub_sovf", 5'b01000, 32'h80000000, 32'h1, 0, 0, 0, 0, 0, 1, 32'h7FFFFFFF, 4'b0001);
        run_op("sra_imm",  5'b01101, 32'h80000000, 32'h0, 32'h24, 1, 0, 0, 0, 1, 32'hF8000000, 4'b0100);
        run_op("srl",      5'b00101, 32'h80000000, 32'd4, 0, 0, 0, 0, 0, 1, 32'h08000000, 4'b0000);
        run_op("sll",      5'b00001, 32'h00000003, 32'd33, 0, 0, 0, 0, 0, 1, 32'h00000006, 4'b0000);
        run_op("slt",      5'b00010, 32'hFFFFFFFF, 32'h1, 0, 0, 0, 0, 0, 1, 32'h1, 4'b0000);
        run_op("sltu",     5'b00011, 32'hFFFFFFFF, 32'h1, 0, 0, 0, 0, 0, 1, 32'h0, 4'b1000);
        run_op("xor",      5'b00100, 32'hF0F0, 32'hFF00, 0, 0, 0, 0, 0, 1, 32'h0FF0, 4'b0000);
        run_op("or",       5'b00110, 32'hF0F0, 32'hFF00, 0, 0, 0, 0, 0, 1, 32'hFFF0, 4'b0000);
        run_op("and",      5'b00111, 32'hF0F0, 32'hFF00, 0, 0, 0, 0, 0, 1, 32'hF000, 4'b0000);
        run_op("undef",    5'b01111, 32'h1234, 32'h1, 0, 0, 0, 0, 0, 1, 32'h0, 4'b1000);
        run_op("auipc",    5'b00000, 32'hDEAD, 32'h0, 32'h20, 1, 1, 1, 32'h1000, 1, 32'h1020, 4'b0000);
        run_op("lui",      5'b00000, 32'hDEAD, 32'h0, 32'h12345000, 1, 0, 1, 32'h1000, 1, 32'h12345000, 4'b0000);

        // M ops: expected latency WIDTH+1.
        run_op("mul",    5'b10000, 32'd7, 32'hFFFFFFFD, 0, 0, 0, 0, 0, W+1, 32'hFFFFFFEB, 4'b0100);
        run_op("mulh",   5'b10001, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 0, W+1, 32'h0, 4'b1000);
        run_op("mulhsu", 5'b10010, 32'hFFFFFFFF, 32'h2, 0, 0, 0, 0, 0, W+1, 32'hFFFFFFFF, 4'b0100);
        run_op("mulhu",  5'b11011, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 0, W+1, 32'hFFFFFFFE, 4'b0100);
        run_op("div_ovf", 5'b10100, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 0, 0, W+1, 32'h80000000, 4'b0100);
        run_op("rem_ovf", 5'b10110, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 0, 0, W+1, 32'h0, 4'b1000);
        run_op("divu_z", 5'b10101, 32'd5, 32'd0, 0, 0, 0, 0, 0, W+1, 32'hFFFFFFFF, 4'b0100);
        run_op("rem_z",  5'b10110, 32'hFFFFFFF9, 32'd0, 0, 0, 0, 0, 0, W+1, 32'hFFFFFFF9, 4'b0100);
        run_op("rem",    5'b10110, 32'hFFFFFFF9, 32'd2, 0, 0, 0, 0, 0, W+1, 32'hFFFFFFFF, 4'b0100);
        run_op("div",    5'b10100, 32'hFFFFFFF9, 32'd2, 0, 0, 0, 0, 0, W+1, 32'hFFFFFFFD, 4'b0100);
        run_op("divu",   5'b10101, 32'd100, 32'd7, 0, 0, 0, 0, 0, W+1, 32'd14, 4'b0000);
        run_op("remu",   5'b10111, 32'd100, 32'd7, 0, 0, 0, 0, 0, W+1, 32'd2, 4'b0000);

        // Back-pressure: result and valid held while out_ready low.
        issue(5'b00000, 32'd2, 32'd3, 0, 0, 0, 0, 0);
        @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("hold/valid_res", {out_valid, in_ready, result[29:0]}, {2'b10, 30'd5});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("hold/ack", 32'({out_valid, in_ready}), 32'b01);

        // Flush mid-DIV: back to IDLE, no result ever appears.
        issue(5'b10100, 32'd100, 32'd7, 0, 0, 0, 0, 0);
        repeat (5) @(negedge clk);
        chk("flush/busy", 32'(in_ready), 32'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush/idle", 32'({out_valid, in_ready}), 32'b01);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("flush/no_valid", 32'(seen), 32'd0);

        // Flush together with in_valid: nothing accepted.
        @(negedge clk);
        op = 5'b00000; rs1 = 32'd1; rs2 = 32'd1; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("flush_in/none", 32'({out_valid, in_ready}), 32'b01);

        // Reset mid-MUL discards it and clears outputs.
        issue(5'b10000, 32'd9, 32'd9, 0, 0, 0, 0, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid/state", 32'({out_valid, in_ready}), 32'b01);
        chk("rst_mid/result", result, 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("rst_mid/no_valid", 32'(seen), 32'd0);
        run_op("post_rst", 5'b10000, 32'd9, 32'd9, 0, 0, 0, 0, 0, W+1, 32'd81, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
